game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter N_OBJ, default 2: number of falling-object lanes sequenced.
REQ-002 SHALL have parameter STAGGER_FRAMES, default 100: frames between successive lane releases.
REQ-003 SHALL have parameter COUNTDOWN_FRAMES, default 180: frames spent in COUNTDOWN.
REQ-004 SHALL have parameter MISS_LIMIT, default 9: miss total that ends the game.
REQ-005 SHALL have port clk_vga, input, 1: pixel clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-008 SHALL have port start_req, input, 1: one-cycle start/restart pulse, already synchronised.
REQ-009 SHALL have port pause_req, input, 1: one-cycle pause-toggle pulse.
REQ-010 SHALL have port hit, input, N_OBJ: per-lane catch pulse, one cycle.
REQ-011 SHALL have port miss_evt, input, N_OBJ: per-lane miss pulse, one cycle.
REQ-012 SHALL have port obj_rst_n, output, N_OBJ: per-lane active-low reset to the object movers.
REQ-013 SHALL have port obj_en, output, N_OBJ: per-lane motion enable.
REQ-014 SHALL have port score, output, 8: saturating catch total.
REQ-015 SHALL have port miss, output, 4: saturating miss total.
REQ-016 SHALL have port state, output, 3: current state encoding.
REQ-017 SHALL have port game_over, output, 1: high while in OVER.

Function
REQ-018 SHALL implement states IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4; all outputs registered.
REQ-019 SHALL move IDLE->COUNTDOWN on start_req, clearing score, miss and all lane timers in the same edge.
REQ-020 SHALL count frame_tick in COUNTDOWN and enter PLAY on the edge after the COUNTDOWN_FRAMES-th tick.
REQ-021 SHALL, in PLAY, release lane k (obj_rst_n[k]=1, obj_en[k]=1) after k*STAGGER_FRAMES frame_ticks since PLAY entry; lane 0 releases on the PLAY entry edge.
REQ-022 SHALL hold obj_rst_n[k]=0 and obj_en[k]=0 for every unreleased lane and in IDLE, COUNTDOWN and OVER.
REQ-023 SHALL add popcount(hit & released-lane mask) to score each cycle in PLAY, saturating at 255.
REQ-024 SHALL add popcount(miss_evt & released-lane mask) to miss each cycle in PLAY, saturating at 15.
REQ-025 SHALL ignore hit and miss_evt outside PLAY and on unreleased lanes.
REQ-026 SHALL enter OVER on the edge after miss reaches or exceeds MISS_LIMIT; a same-cycle hit still counts.
REQ-027 SHALL move OVER->COUNTDOWN on start_req, clearing score, miss and timers; start_req in COUNTDOWN or PLAY SHALL be ignored.
REQ-028 SHALL keep score and miss stable in OVER until the restart edge.

Reset
REQ-029 SHALL, while rst=0, force state=IDLE, score=0, miss=0, obj_rst_n=0, obj_en=0, game_over=0 and clear all counters, asynchronously.
REQ-030 SHALL start from IDLE on the first clk_vga edge after rst deasserts, including a deassertion mid-PLAY.

Configuration
REQ-031 SHALL compile PAUSE support only when macro GAME_CTRL_PAUSE_EN is defined.
REQ-032 SHALL, with GAME_CTRL_PAUSE_EN, toggle PLAY<->PAUSE on pause_req; PAUSE drops obj_en to 0, keeps obj_rst_n, freezes the stagger and countdown timers and ignores hit/miss_evt.
REQ-033 SHALL, without GAME_CTRL_PAUSE_EN, ignore pause_req and never reach state 3.

Structure
REQ-034 SHALL take state encodings, the 8-bit score width and the 4-bit miss width from shared package game_pkg.
REQ-035 SHALL instantiate sub-module lane_stagger once per lane: a frame counter with clear, freeze and release-threshold inputs, producing a sticky released flag.

Verification
REQ-036 SHALL cover: reset, start_req, 180 frame_ticks -> state=2 on the following edge, obj_en=2'b01; obj_en=2'b11 after 100 more ticks.
REQ-037 SHALL cover: in PLAY with both lanes released, hit=2'b11 for one cycle at score=254 -> score=255, then hit=2'b01 -> score stays 255.
REQ-038 SHALL cover: miss=8, miss_evt=2'b01 with hit=2'b01 in the same cycle -> miss=9, score+1, state=4 and game_over=1 one edge later.
REQ-039 SHALL cover: hit=2'b10 before lane 1 released -> score unchanged; start_req during PLAY -> no state change.
REQ-040 SHALL cover: with GAME_CTRL_PAUSE_EN, pause_req at tick 50 of stagger, 30 ticks, pause_req -> lane 1 releases at 100 PLAY-tick total; without the macro -> state stays 2.
REQ-041 SHALL cover: rst=0 mid-PLAY at score=7 -> all outputs at reset values immediately, without a clk_vga edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, score/miss widths and a popcount helper.
package game_pkg;

  localparam int SCORE_W = 8;
  localparam int MISS_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lane_stagger.sv
// Per-lane release timer: counts frame ticks while not frozen and latches a
// sticky released flag once the count reaches the lane's threshold.
module lane_stagger #(
  parameter int CNT_W = 7
) (
  input  logic             clk_vga,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_frz,
  input  logic             i_tick,
  input  logic             i_arm,
  input  logic [CNT_W-1:0] i_thresh,
  output logic             o_released,
  output logic             o_released_nxt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_released;
  logic             w_released_nxt;

  // Next count and release; counting stops once the lane is out
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_released_nxt = r_released;
    if (i_clr) begin
      w_cnt_nxt      = '0;
      w_released_nxt = 1'b0;
    end else begin
      if (!i_frz && i_tick && !r_released) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
      if (i_arm && (w_cnt_nxt >= i_thresh)) begin
        w_released_nxt = 1'b1;
      end else begin
        w_released_nxt = r_released;
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_released <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_released <= w_released_nxt;
    end
  end

  assign o_released     = r_released;
  assign o_released_nxt = w_released_nxt;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: countdown, staggered lane release, saturating score/miss, game over.
// Optional PLAY<->PAUSE toggling is built only when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl
  import game_pkg::*;
#(
  parameter int N_OBJ            = 2,
  parameter int STAGGER_FRAMES   = 100,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int MISS_LIMIT       = 9
) (
  input  logic               clk_vga,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_req,
  input  logic               pause_req,
  input  logic [N_OBJ-1:0]   hit,
  input  logic [N_OBJ-1:0]   miss_evt,
  output logic [N_OBJ-1:0]   obj_rst_n,
  output logic [N_OBJ-1:0]   obj_en,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  miss,
  output logic [2:0]         state,
  output logic               game_over
);

  localparam int CNT_W = $clog2((N_OBJ - 1) * STAGGER_FRAMES + 2);
  localparam int CD_W  = $clog2(COUNTDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0]    CD_LAST   = CD_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [MISS_W-1:0]  MISS_LIM  = MISS_W'(MISS_LIMIT);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [MISS_W-1:0]  MISS_MAX  = '1;

`ifdef GAME_CTRL_PAUSE_EN
  localparam logic PAUSE_EN = 1'b1;
`else
  localparam logic PAUSE_EN = 1'b0;
`endif

  state_e               r_state, w_state_nxt;
  logic [CD_W-1:0]      r_cd_cnt, w_cd_nxt;
  logic [SCORE_W-1:0]   r_score, w_score_nxt;
  logic [MISS_W-1:0]    r_miss, w_miss_nxt;
  logic [N_OBJ-1:0]     r_obj_en, r_obj_rst_n, w_obj_en_nxt, w_obj_rst_n_nxt;
  logic                 r_game_over;
  logic [N_OBJ-1:0]     w_rel, w_rel_nxt;
  logic                 w_clr, w_pause_go;
  logic [5:0]           w_hit_cnt, w_miss_cnt;
  logic [SCORE_W+5:0]   w_score_sum;
  logic [MISS_W+5:0]    w_miss_sum;
  logic [SCORE_W-1:0]   w_score_sat;
  logic [MISS_W-1:0]    w_miss_sat;

  assign w_pause_go = pause_req & PAUSE_EN;

  for (genvar k = 0; k < N_OBJ; k++) begin : g_lane
    lane_stagger #(.CNT_W(CNT_W)) u_lane (
      .clk_vga        (clk_vga),
      .rst            (rst),
      .i_clr          (w_clr),
      .i_frz          (r_state != ST_PLAY),
      .i_tick         (frame_tick),
      .i_arm          (w_state_nxt == ST_PLAY),
      .i_thresh       (CNT_W'(k * STAGGER_FRAMES)),
      .o_released     (w_rel[k]),
      .o_released_nxt (w_rel_nxt[k])
    );
  end

  // Saturating totals over released lanes only
  always_comb begin
    w_hit_cnt   = popcount32(32'(hit & w_rel));
    w_miss_cnt  = popcount32(32'(miss_evt & w_rel));
    w_score_sum = (SCORE_W + 6)'(r_score) + (SCORE_W + 6)'(w_hit_cnt);
    w_miss_sum  = (MISS_W + 6)'(r_miss) + (MISS_W + 6)'(w_miss_cnt);
    if (w_score_sum > (SCORE_W + 6)'(SCORE_MAX)) begin
      w_score_sat = SCORE_MAX;
    end else begin
      w_score_sat = w_score_sum[SCORE_W-1:0];
    end
    if (w_miss_sum > (MISS_W + 6)'(MISS_MAX)) begin
      w_miss_sat = MISS_MAX;
    end else begin
      w_miss_sat = w_miss_sum[MISS_W-1:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd_cnt;
    w_score_nxt = r_score;
    w_miss_nxt  = r_miss;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start_req) begin
          w_state_nxt = ST_COUNTDOWN;
          w_cd_nxt    = '0;
          w_score_nxt = '0;
          w_miss_nxt  = '0;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_COUNTDOWN: begin
        if (frame_tick && (r_cd_cnt >= CD_LAST)) begin
          w_state_nxt = ST_PLAY;
          w_cd_nxt    = '0;
        end else if (frame_tick) begin
          w_cd_nxt = r_cd_cnt + CD_W'(1);
        end else begin
          w_cd_nxt = r_cd_cnt;
        end
      end
      ST_PLAY: begin
        w_score_nxt = w_score_sat;
        w_miss_nxt  = w_miss_sat;
        // The limit is judged on the registered total, so the final miss shows for one cycle
        if (r_miss >= MISS_LIM) begin
          w_state_nxt = ST_OVER;
        end else if (w_pause_go) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (pause_req) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt == ST_PLAY) begin
      w_obj_en_nxt = w_rel_nxt;
    end else begin
      w_obj_en_nxt = '0;
    end
    if ((w_state_nxt == ST_PLAY) || (w_state_nxt == ST_PAUSE)) begin
      w_obj_rst_n_nxt = w_rel_nxt;
    end else begin
      w_obj_rst_n_nxt = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cd_cnt    <= '0;
      r_score     <= '0;
      r_miss      <= '0;
      r_obj_en    <= '0;
      r_obj_rst_n <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cd_cnt    <= w_cd_nxt;
      r_score     <= w_score_nxt;
      r_miss      <= w_miss_nxt;
      r_obj_en    <= w_obj_en_nxt;
      r_obj_rst_n <= w_obj_rst_n_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  assign obj_rst_n = r_obj_rst_n;
  assign obj_en    = r_obj_en;
  assign score     = r_score;
  assign miss      = r_miss;
  assign state     = r_state;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: expected outputs are queued per driven cycle
// and compared one step after the active edge; adapts to GAME_CTRL_PAUSE_EN.
module tb_game_ctrl;

  logic       clk_vga = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0, start_req = 1'b0, pause_req = 1'b0;
  logic [1:0] hit = 2'b00, miss_evt = 2'b00;
  logic [1:0] obj_rst_n, obj_en;
  logic [7:0] score;
  logic [3:0] miss;
  logic [2:0] state;
  logic       game_over;

`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  game_ctrl dut (
    .clk_vga(clk_vga), .rst(rst), .frame_tick(frame_tick), .start_req(start_req),
    .pause_req(pause_req), .hit(hit), .miss_evt(miss_evt), .obj_rst_n(obj_rst_n),
    .obj_en(obj_en), .score(score), .miss(miss), .state(state), .game_over(game_over)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct packed {
    logic [2:0] st; logic [7:0] sc; logic [3:0] ms; logic [1:0] en; logic [1:0] rn; logic go;
  } exp_t;

  typedef struct {
    logic s; logic p; logic [1:0] h; logic [1:0] m; logic t; exp_t e;
  } vec_t;

  exp_t  q_exp[$];
  string q_tag[$];
  exp_t  c_exp;
  string c_tag;
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic exp_t mk_exp(input int st, input int sc, input int ms,
                                  input logic [1:0] en, input logic [1:0] rn, input logic go);
    exp_t r;
    r.st = 3'(st); r.sc = 8'(sc); r.ms = 4'(ms); r.en = en; r.rn = rn; r.go = go;
    return r;
  endfunction

  function automatic vec_t mk_vec(input logic s, input logic p, input logic [1:0] h,
                                  input logic [1:0] m, input logic t, input exp_t e);
    vec_t v;
    v.s = s; v.p = p; v.h = h; v.m = m; v.t = t; v.e = e;
    return v;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    n_vec++;
    if (state !== e.st || score !== e.sc || miss !== e.ms || obj_en !== e.en ||
        obj_rst_n !== e.rn || game_over !== e.go) begin
      n_bad++;
      $display("FAIL %s: got st=%0d sc=%0d ms=%0d en=%b rn=%b go=%b, expected st=%0d sc=%0d ms=%0d en=%b rn=%b go=%b",
               tag, state, score, miss, obj_en, obj_rst_n, game_over,
               e.st, e.sc, e.ms, e.en, e.rn, e.go);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge
  task automatic step(input logic s, input logic p, input logic [1:0] h, input logic [1:0] m,
                      input logic t, input exp_t e, input string tag);
    @(posedge clk_vga);
    #2;
    start_req = s; pause_req = p; hit = h; miss_evt = m; frame_tick = t;
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic do_countdown();
    for (int i = 1; i <= 180; i++) begin
      if (i == 90) step(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0), "cd_no_tick");
      step(1'b0, 1'b0, 2'b00, 2'b00, 1'b1,
           (i == 180) ? mk_exp(2, 0, 0, 2'b01, 2'b01, 1'b0) : mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0),
           (i == 180) ? "cd_to_play" : "countdown");
    end
  endtask

  // Scoreboard: pop and compare 1 time unit after each active edge
  always @(posedge clk_vga) begin
    #1;
    if (q_exp.size() > 0) begin
      c_exp = q_exp.pop_front();
      c_tag = q_tag.pop_front();
      compare(c_tag, c_exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[12];
    int         sc, pt;
    logic [1:0] vh, vm;
    logic       vs;

    tbl[0]  = mk_vec(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, mk_exp(2, 255, 0, 2'b11, 2'b11, 1'b0));
    tbl[1]  = mk_vec(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, mk_exp(2, 255, 0, 2'b11, 2'b11, 1'b0));
    tbl[2]  = mk_vec(1'b0, 1'b0, 2'b10, 2'b01, 1'b0, mk_exp(2, 255, 1, 2'b11, 2'b11, 1'b0));
    tbl[3]  = mk_vec(1'b0, 1'b0, 2'b00, 2'b11, 1'b1, mk_exp(2, 255, 3, 2'b11, 2'b11, 1'b0));
    tbl[4]  = mk_vec(1'b1, 1'b0, 2'b00, 2'b11, 1'b0, mk_exp(2, 255, 5, 2'b11, 2'b11, 1'b0));
    tbl[5]  = mk_vec(1'b0, 1'b0, 2'b00, 2'b11, 1'b0, mk_exp(2, 255, 7, 2'b11, 2'b11, 1'b0));
    tbl[6]  = mk_vec(1'b0, 1'b0, 2'b00, 2'b10, 1'b0, mk_exp(2, 255, 8, 2'b11, 2'b11, 1'b0));
    tbl[7]  = mk_vec(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, mk_exp(2, 255, 9, 2'b11, 2'b11, 1'b0));
    tbl[8]  = mk_vec(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(4, 255, 9, 2'b00, 2'b00, 1'b1));
    tbl[9]  = mk_vec(1'b0, 1'b0, 2'b11, 2'b11, 1'b0, mk_exp(4, 255, 9, 2'b00, 2'b00, 1'b1));
    tbl[10] = mk_vec(1'b0, 1'b1, 2'b00, 2'b00, 1'b1, mk_exp(4, 255, 9, 2'b00, 2'b00, 1'b1));
    tbl[11] = mk_vec(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0));

    #12;
    compare("reset_state", mk_exp(0, 0, 0, 2'b00, 2'b00, 1'b0));
    #11;
    rst = 1'b1;
    step(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, mk_exp(0, 0, 0, 2'b00, 2'b00, 1'b0), "idle_hold");
    step(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0), "start");
    do_countdown();

    // Lane 1 stagger, with ignored hits/misses/start and optional pause window
    sc = 0; pt = 0;
    for (int i = 1; i <= 50; i++) begin
      vh = (i == 10) ? 2'b10 : ((i == 30) ? 2'b01 : 2'b00);
      vm = (i == 40) ? 2'b10 : 2'b00;
      vs = (i == 20);
      if (i == 30) sc++;
      pt++;
      step(vs, 1'b0, vh, vm, 1'b1, mk_exp(2, sc, 0, 2'b01, 2'b01, 1'b0), "play_lane0");
    end
    step(1'b0, 1'b1, 2'b00, 2'b00, 1'b0,
         PE ? mk_exp(3, sc, 0, 2'b00, 2'b01, 1'b0) : mk_exp(2, sc, 0, 2'b01, 2'b01, 1'b0), "pause_on");
    for (int j = 1; j <= 30; j++) begin
      vh = (j == 15) ? 2'b01 : 2'b00;
      if (j == 15 && !PE) sc++;
      if (!PE) pt++;
      step(1'b0, 1'b0, vh, 2'b00, 1'b1,
           PE ? mk_exp(3, sc, 0, 2'b00, 2'b01, 1'b0) : mk_exp(2, sc, 0, 2'b01, 2'b01, 1'b0), "paused");
    end
    step(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, mk_exp(2, sc, 0, 2'b01, 2'b01, 1'b0), "pause_off");
    while (pt < 100) begin
      pt++;
      step(1'b0, 1'b0, 2'b00, 2'b00, 1'b1,
           mk_exp(2, sc, 0, (pt >= 100) ? 2'b11 : 2'b01, (pt >= 100) ? 2'b11 : 2'b01, 1'b0), "stagger");
    end

    while (sc < 254) begin
      if (254 - sc >= 2) begin vh = 2'b11; sc += 2; end
      else begin vh = 2'b01; sc++; end
      step(1'b0, 1'b0, vh, 2'b00, 1'b0, mk_exp(2, sc, 0, 2'b11, 2'b11, 1'b0), "score_pump");
    end
    for (int v = 0; v < 12; v++) begin
      step(tbl[v].s, tbl[v].p, tbl[v].h, tbl[v].m, tbl[v].t, tbl[v].e, $sformatf("tbl%0d", v));
    end

    // Final miss with a same-cycle hit
    do_countdown();
    for (int k = 1; k <= 8; k++) begin
      vh = (k == 4) ? 2'b01 : 2'b00;
      step(1'b0, 1'b0, vh, 2'b01, 1'b0, mk_exp(2, (k >= 4) ? 1 : 0, k, 2'b01, 2'b01, 1'b0), "miss_ramp");
    end
    step(1'b0, 1'b0, 2'b01, 2'b01, 1'b0, mk_exp(2, 2, 9, 2'b01, 2'b01, 1'b0), "last_miss_hit");
    step(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(4, 2, 9, 2'b00, 2'b00, 1'b1), "over_entry");

    // Asynchronous reset mid-PLAY at score 7
    step(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0), "restart");
    do_countdown();
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, mk_exp(2, k, 0, 2'b01, 2'b01, 1'b0), "score_to_7");
    end
    @(posedge clk_vga);
    #2;
    start_req = 1'b0; pause_req = 1'b0; hit = 2'b00; miss_evt = 2'b00; frame_tick = 1'b0;
    rst = 1'b0;
    #1;
    compare("async_reset", mk_exp(0, 0, 0, 2'b00, 2'b00, 1'b0));
    repeat (2) @(posedge clk_vga);
    #1;
    compare("reset_held", mk_exp(0, 0, 0, 2'b00, 2'b00, 1'b0));
    #3;
    rst = 1'b1;
    step(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, mk_exp(0, 0, 0, 2'b00, 2'b00, 1'b0), "post_reset_idle");
    step(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0), "post_reset_start");
    step(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, mk_exp(1, 0, 0, 2'b00, 2'b00, 1'b0), "countdown_hold");
    repeat (2) @(posedge clk_vga);
    #2;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
